result_pager: RTL and testbench
===============================

RESULT_PAGER -- requirements
Module: result_pager

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable synchronized cycles needed to accept a key level change.
REQ-002 The block SHALL have parameter PAGES, fixed at 4: number of 8-bit pages in the 32-bit result.
REQ-003 Port clk  input  1: the single clock; all logic is on its rising edge.
REQ-004 Port rst  input  1: synchronous, active-high reset.
REQ-005 Port i_result  input  32: result word from the ALU, for example an IEEE-754 single.
REQ-006 Port i_valid  input  1: i_result is valid and offered.
REQ-007 Port o_ready  output  1: block can accept a result.
REQ-008 Port key_next  input  1: pushbutton, asynchronous, active low; advances to the next page.
REQ-009 Port key_clear  input  1: pushbutton, asynchronous, active low; releases the displayed result.
REQ-010 Port o_LED  output  8: registered byte currently displayed.
REQ-011 Port o_page  output  2: index of the displayed page (0 = bits 7:0, 3 = bits 31:24).
REQ-012 Port o_busy  output  1: a result is held and shown.

Function
REQ-013 Each key SHALL pass through a 2-flop synchronizer, reset value 1.
REQ-014 A debounced key level SHALL change only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles.
- Any bounce back restarts the count.
REQ-015 A press event SHALL be a single-cycle pulse on the debounced 1->0 transition.
- Exactly one event per physical press, however long the key is held.
- Release generates no event.
REQ-016 A press event SHALL occur no later than DEBOUNCE_CYCLES+3 cycles after a clean key fall.
REQ-017 The FSM SHALL have exactly two states, IDLE and SHOW; o_busy=1 only in SHOW.
REQ-018 In IDLE the block SHALL drive o_ready=1, o_LED=0x00 and o_page=0.
REQ-019 Handshake: a transfer SHALL occur on an edge where i_valid=1 and o_ready=1.
- On that edge: held<=i_result, page<=0, o_LED<=i_result[7:0], state<=SHOW.
- o_ready drops the following cycle.
REQ-020 In SHOW the block SHALL drive o_ready=0.
- i_valid SHALL be ignored; the producer holds its data until o_ready returns.
REQ-021 A key_next event in SHOW SHALL, on the same edge:
- page<=page+1, wrapping 3->0;
- o_LED<=held[8*newpage+7 : 8*newpage].
REQ-022 A key_clear event in SHOW SHALL, on the same edge:
- state<=IDLE, o_LED<=0x00, page<=0, held<=0.
REQ-023 When key_next and key_clear events occur in the same cycle, key_clear SHALL win and the page SHALL NOT advance.
REQ-024 Key events in IDLE SHALL be ignored, with no pending or queued effect.
REQ-025 After key_clear, a result offered with i_valid SHALL be accepted on the edge after IDLE is entered.
- No result is ever accepted on the same edge as the clear.
REQ-026 The block SHALL never modify held while in SHOW.
REQ-027 o_page SHALL always equal the index of the byte on o_LED.

Reset
REQ-028 While rst=1 at a rising edge, the block SHALL set:
- state=IDLE, held=0, page=0, o_LED=0x00, o_busy=0;
- debounce counters=0, synchronizers and debounced levels=1 (released).
REQ-029 o_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-030 Reset mid-operation SHALL discard the held result and any partially debounced press.
- A key still held low across reset deassertion SHALL produce one event after DEBOUNCE_CYCLES stable cycles.

Verification (DEBOUNCE_CYCLES=4)
REQ-031 Accept: reset, then i_result=0x4049_0FDB with i_valid=1 for one cycle -> next cycle o_LED=0xDB, o_page=0, o_busy=1, o_ready=0.
REQ-032 Paging: four clean key_next presses, each held 10 cycles -> o_LED steps 0x0F, 0x49, 0x40, 0xDB and o_page steps 1, 2, 3, 0; exactly one step per press.
REQ-033 Bounce: key_next low 3 cycles, high 1, low 3, then high -> no page change; then held low 10 cycles -> exactly one advance.
REQ-034 Backpressure: in SHOW, offer 0x1234_5678 with i_valid held high -> o_ready=0 and o_LED unchanged; key_clear -> o_LED=0x00, then accepted one cycle later with o_LED=0x78.
REQ-035 Simultaneous: key_next and key_clear fall on the same cycle while on page 1 -> state IDLE, o_LED=0x00, o_page=0.
REQ-036 Reset mid-show: rst pulsed while on page 2 -> next cycle o_LED=0x00, o_page=0, o_busy=0, o_ready=1.

Source files
------------

// File: rtl/result_pager.sv
// Latches one 32-bit result and pages through its bytes on an 8-bit LED bank,
// stepped and released by two debounced active-low pushbuttons.
module result_pager #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PAGES           = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                i_result,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic                       key_next,
  input  logic                       key_clear,
  output logic [7:0]                 o_LED,
  output logic [$clog2(PAGES)-1:0]   o_page,
  output logic                       o_busy
);

  localparam int PW = $clog2(PAGES);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SHOW = 1'b1;

  // Key index 0 is key_next, index 1 is key_clear.
  localparam int K_NEXT  = 0;
  localparam int K_CLEAR = 1;

  function automatic logic [7:0] page_byte(input logic [31:0] word, input logic [PW-1:0] pg);
    logic [7:0] b;
    case (pg)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  logic [1:0]          sync1_q, sync1_d;
  logic [1:0]          sync2_q, sync2_d;
  logic [1:0]          level_q, level_d;
  logic [1:0][CW-1:0]  cnt_q, cnt_d;
  logic [1:0]          press_s;

  logic [0:0]          state_q, state_d;
  logic [31:0]         held_q, held_d;
  logic [PW-1:0]       page_q, page_d;
  logic [PW-1:0]       page_n_s;
  logic [7:0]          led_q, led_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;

  // Synchronize and debounce both keys; a press pulses on the accepted 1->0 change.
  always_comb begin
    sync1_d = {key_clear, key_next};
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    press_s = 2'b00;
    for (int k = 0; k < 2; k++) begin
      if (sync2_q[k] != level_q[k]) begin
        if (cnt_q[k] == CNT_LAST) begin
          level_d[k] = sync2_q[k];
          press_s[k] = ~sync2_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + CNT_ONE;
        end
      end else begin
        cnt_d[k] = '0;
      end
    end
  end

  // Two-state display FSM: accept a result in IDLE, page or release it in SHOW.
  always_comb begin
    state_d  = state_q;
    held_d   = held_q;
    page_d   = page_q;
    led_d    = led_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    page_n_s = page_q + PW'(1);
    case (state_q)
      ST_IDLE: begin
        if (i_valid && ready_q) begin
          held_d  = i_result;
          page_d  = '0;
          led_d   = i_result[7:0];
          state_d = ST_SHOW;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end else begin
          page_d  = '0;
          led_d   = 8'h00;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      ST_SHOW: begin
        // Clear has priority over a coincident next.
        if (press_s[K_CLEAR]) begin
          state_d = ST_IDLE;
          held_d  = 32'h0000_0000;
          page_d  = '0;
          led_d   = 8'h00;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end else if (press_s[K_NEXT]) begin
          page_d = page_n_s;
          led_d  = page_byte(held_q, page_n_s);
        end else begin
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        held_d  = 32'h0000_0000;
        page_d  = '0;
        led_d   = 8'h00;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset; keys reset to the released level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      level_q <= 2'b11;
      cnt_q   <= '0;
      state_q <= ST_IDLE;
      held_q  <= 32'h0000_0000;
      page_q  <= '0;
      led_q   <= 8'h00;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      held_q  <= held_d;
      page_q  <= page_d;
      led_q   <= led_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign o_ready = ready_q;
  assign o_LED   = led_q;
  assign o_page  = page_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_result_pager.sv
// Directed plus randomized check of result_pager against a window-based
// debounce model and a transaction-level display model.
module tb_result_pager;
  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_result;
  logic        i_valid;
  logic        o_ready;
  logic        key_next;
  logic        key_clear;
  logic [7:0]  o_LED;
  logic [1:0]  o_page;
  logic        o_busy;

  result_pager #(.DEBOUNCE_CYCLES(DB), .PAGES(4)) dut (
    .clk(clk), .rst(rst), .i_result(i_result), .i_valid(i_valid), .o_ready(o_ready),
    .key_next(key_next), .key_clear(key_clear), .o_LED(o_LED), .o_page(o_page), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: a key level flips once the last DB synchronized samples
  // (raw samples two edges old and earlier) all disagree with it.
  logic [DB+1:0] hist_n, hist_c;
  logic          lvl_n, lvl_c;
  logic          m_show;
  logic [31:0]   m_held;
  logic [1:0]    m_page;
  logic [7:0]    m_led;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic deb(inout logic [DB+1:0] h, inout logic lvl, input logic raw, output logic ev);
    h  = {h[DB:0], raw};
    ev = 1'b0;
    if (h[DB+1:2] == {DB{~lvl}}) begin
      ev  = lvl;
      lvl = ~lvl;
    end
  endtask

  task automatic tick();
    logic        s_rst, s_val, s_kn, s_kc, ev_n, ev_c;
    logic [31:0] s_res, shifted;
    s_rst = rst; s_val = i_valid; s_kn = key_next; s_kc = key_clear; s_res = i_result;
    @(posedge clk);
    #1;
    if (s_rst) begin
      hist_n = '1; hist_c = '1; lvl_n = 1'b1; lvl_c = 1'b1;
      m_show = 1'b0; m_held = 32'h0; m_page = 2'd0; m_led = 8'h00;
    end else begin
      deb(hist_n, lvl_n, s_kn, ev_n);
      deb(hist_c, lvl_c, s_kc, ev_c);
      if (!m_show) begin
        if (s_val) begin
          m_held = s_res; m_page = 2'd0; m_led = s_res[7:0]; m_show = 1'b1;
        end
      end else if (ev_c) begin
        m_show = 1'b0; m_held = 32'h0; m_page = 2'd0; m_led = 8'h00;
      end else if (ev_n) begin
        m_page  = 2'((m_page + 1) % 4);
        shifted = m_held >> (8 * m_page);
        m_led   = shifted[7:0];
      end
    end
    chk("led",   {24'h0, o_LED},   {24'h0, m_led});
    chk("page",  {30'h0, o_page},  {30'h0, m_page});
    chk("busy",  {31'h0, o_busy},  {31'h0, m_show});
    chk("ready", {31'h0, o_ready}, {31'h0, ~m_show});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press_next(input int low, input int high);
    key_next = 1'b0; ticks(low);
    key_next = 1'b1; ticks(high);
  endtask

  logic [7:0] step_led [4];
  int         guard;

  initial begin
    step_led[0] = 8'h0F; step_led[1] = 8'h49; step_led[2] = 8'h40; step_led[3] = 8'hDB;
    hist_n = '1; hist_c = '1; lvl_n = 1'b1; lvl_c = 1'b1;
    m_show = 1'b0; m_held = 32'h0; m_page = 2'd0; m_led = 8'h00;
    rst = 1'b1; i_valid = 1'b0; i_result = 32'h0; key_next = 1'b1; key_clear = 1'b1;
    #1;
    ticks(2);
    chk("rst_led", {24'h0, o_LED}, 32'h0);
    chk("rst_busy", {31'h0, o_busy}, 32'h0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", {31'h0, o_ready}, 32'h1);

    // Accept
    i_result = 32'h4049_0FDB; i_valid = 1'b1; tick();
    i_valid = 1'b0;
    chk("acc_led", {24'h0, o_LED}, 32'hDB);
    chk("acc_page", {30'h0, o_page}, 32'h0);
    chk("acc_busy", {31'h0, o_busy}, 32'h1);
    chk("acc_ready", {31'h0, o_ready}, 32'h0);

    // Paging: one step per clean press
    for (int p = 0; p < 4; p++) begin
      press_next(10, 10);
      chk("pg_led", {24'h0, o_LED}, {24'h0, step_led[p]});
      chk("pg_page", {30'h0, o_page}, 32'((p + 1) % 4));
    end

    // Bounce: no change, then one clean press gives exactly one advance
    key_next = 1'b0; ticks(3); key_next = 1'b1; ticks(1);
    key_next = 1'b0; ticks(3); key_next = 1'b1; ticks(10);
    chk("bounce_page", {30'h0, o_page}, 32'h0);
    chk("bounce_led", {24'h0, o_LED}, 32'hDB);
    press_next(10, 10);
    chk("clean_page", {30'h0, o_page}, 32'h1);
    chk("clean_led", {24'h0, o_LED}, 32'h0F);

    // Backpressure, then clear and accept one edge after IDLE
    i_result = 32'h1234_5678; i_valid = 1'b1; ticks(5);
    chk("bp_ready", {31'h0, o_ready}, 32'h0);
    chk("bp_led", {24'h0, o_LED}, 32'h0F);
    key_clear = 1'b0;
    guard = 0;
    while (o_busy === 1'b1 && guard < 20) begin tick(); guard++; end
    chk("clear_timeout", {31'h0, (guard < 20)}, 32'h1);
    chk("clr_led", {24'h0, o_LED}, 32'h0);
    chk("clr_ready", {31'h0, o_ready}, 32'h1);
    tick();
    chk("reacc_led", {24'h0, o_LED}, 32'h78);
    chk("reacc_busy", {31'h0, o_busy}, 32'h1);
    i_valid = 1'b0; ticks(10);
    key_clear = 1'b1; ticks(10);
    chk("hold_clear_once", {24'h0, o_LED}, 32'h78);

    // Simultaneous next and clear on page 1
    press_next(10, 10);
    chk("sim_pre_page", {30'h0, o_page}, 32'h1);
    key_next = 1'b0; key_clear = 1'b0; ticks(10);
    chk("sim_busy", {31'h0, o_busy}, 32'h0);
    chk("sim_led", {24'h0, o_LED}, 32'h0);
    chk("sim_page", {30'h0, o_page}, 32'h0);
    key_next = 1'b1; key_clear = 1'b1; ticks(10);

    // Reset while on page 2
    i_result = 32'hAABB_CCDD; i_valid = 1'b1; tick(); i_valid = 1'b0;
    press_next(10, 10); press_next(10, 10);
    chk("pre_rst_led", {24'h0, o_LED}, 32'hBB);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mrst_led", {24'h0, o_LED}, 32'h0);
    chk("mrst_page", {30'h0, o_page}, 32'h0);
    chk("mrst_busy", {31'h0, o_busy}, 32'h0);
    chk("mrst_ready", {31'h0, o_ready}, 32'h1);

    // Key held low across reset produces one event afterwards
    i_result = 32'h1122_3344; i_valid = 1'b1; tick(); i_valid = 1'b0;
    key_next = 1'b0; ticks(2);
    rst = 1'b1; tick(); rst = 1'b0;
    i_valid = 1'b1; tick(); i_valid = 1'b0;
    ticks(12);
    chk("xrst_page", {30'h0, o_page}, 32'h1);
    chk("xrst_led", {24'h0, o_LED}, 32'h33);
    key_next = 1'b1; ticks(10);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7, 0) == 0) key_next  = ~key_next;
      if ($urandom_range(15, 0) == 0) key_clear = ~key_clear;
      i_valid  = ($urandom_range(3, 0) == 0);
      i_result = $urandom;
      rst      = ($urandom_range(599, 0) == 0);
      tick();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
